// File: rtl/answer_judge.sv
// Answer judge for the quiz: collects two factor picks, compares them against the
// expected pair in either order, tracks hit points and per-question wrong count.
module answer_judge #(
  parameter int HP_INIT   = 3,
  parameter int WRONG_MAX = 3,
  parameter int SW        = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          QUE_START,
  input  logic [SW-1:0] ANS_A,
  input  logic [SW-1:0] ANS_B,
  input  logic [SW-1:0] SEL,
  input  logic          DEC,
  input  logic          CLR,
  input  logic          ACK,
  input  logic          NEW_GAME,
  output logic          SLOT_OUT,
  output logic          OK_OUT,
  output logic [1:0]    JUDG_OUT,
  output logic [1:0]    WRONG_OUT,
  output logic [1:0]    HP_OUT
);

  typedef enum logic [2:0] {
    IDLE, SLOT0, SLOT1, JUDGE, RESULT, OVER
  } state_e;

  localparam logic [1:0] J_NONE  = 2'b00;
  localparam logic [1:0] J_RIGHT = 2'b01;
  localparam logic [1:0] J_WRONG = 2'b10;
  localparam logic [1:0] J_OVER  = 2'b11;
  localparam logic [1:0] HP_RST  = 2'(HP_INIT);
  localparam logic [1:0] WR_MAX  = 2'(WRONG_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] ans_a_q, ans_a_d, ans_b_q, ans_b_d;
  logic [SW-1:0] pick0_q, pick0_d, pick1_q, pick1_d;
  logic          slot_q, slot_d, ok_q, ok_d;
  logic [1:0]    judg_q, judg_d, wrong_q, wrong_d, hp_q, hp_d;
  logic          match;
  logic [1:0]    hp_dec;

  // Either-order match; A==B naturally needs both picks equal to it.
  assign match  = ((pick0_q == ans_a_q) && (pick1_q == ans_b_q)) ||
                  ((pick0_q == ans_b_q) && (pick1_q == ans_a_q));
  assign hp_dec = (hp_q == 2'd0) ? 2'd0 : hp_q - 2'd1;

  always_comb begin
    state_d = state_q;
    ans_a_d = ans_a_q;
    ans_b_d = ans_b_q;
    pick0_d = pick0_q;
    pick1_d = pick1_q;
    ok_d    = ok_q;
    judg_d  = judg_q;
    wrong_d = wrong_q;
    hp_d    = hp_q;
    unique case (state_q)
      IDLE: if (QUE_START) begin
        ans_a_d = ANS_A;
        ans_b_d = ANS_B;
        wrong_d = 2'd0;
        judg_d  = J_NONE;
        state_d = SLOT0;
      end
      SLOT0: if (!CLR && DEC) begin
        pick0_d = SEL;
        state_d = SLOT1;
      end
      SLOT1: begin
        if (CLR) begin
          pick0_d = '0;
          state_d = SLOT0;
        end else if (DEC) begin
          pick1_d = SEL;
          state_d = JUDGE;
        end
      end
      JUDGE: begin
        ok_d = 1'b1;
        if (match) begin
          judg_d  = J_RIGHT;
          state_d = RESULT;
        end else begin
          wrong_d = (wrong_q == 2'd3) ? 2'd3 : wrong_q + 2'd1;
          hp_d    = hp_dec;
          if (hp_dec == 2'd0) begin
            judg_d  = J_OVER;
            state_d = OVER;
          end else begin
            judg_d  = J_WRONG;
            state_d = RESULT;
          end
        end
      end
      RESULT: if (ACK) begin
        ok_d   = 1'b0;
        judg_d = J_NONE;
        if (judg_q == J_WRONG && wrong_q < WR_MAX) begin
          pick0_d = '0;
          pick1_d = '0;
          state_d = SLOT0;
        end else begin
          state_d = IDLE;
        end
      end
      OVER: if (NEW_GAME) begin
        hp_d    = HP_RST;
        wrong_d = 2'd0;
        judg_d  = J_NONE;
        ok_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    slot_d = (state_d == SLOT1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ans_a_q <= '0;
      ans_b_q <= '0;
      pick0_q <= '0;
      pick1_q <= '0;
      slot_q  <= 1'b0;
      ok_q    <= 1'b0;
      judg_q  <= J_NONE;
      wrong_q <= 2'd0;
      hp_q    <= HP_RST;
    end else begin
      state_q <= state_d;
      ans_a_q <= ans_a_d;
      ans_b_q <= ans_b_d;
      pick0_q <= pick0_d;
      pick1_q <= pick1_d;
      slot_q  <= slot_d;
      ok_q    <= ok_d;
      judg_q  <= judg_d;
      wrong_q <= wrong_d;
      hp_q    <= hp_d;
    end
  end

  assign SLOT_OUT  = slot_q;
  assign OK_OUT    = ok_q;
  assign JUDG_OUT  = judg_q;
  assign WRONG_OUT = wrong_q;
  assign HP_OUT    = hp_q;

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: default instance plus a WRONG_MAX=2 instance.
module tb_answer_judge;
  logic       CLK = 1'b0;
  logic       RST = 1'b0, QUE_START = 1'b0, DEC = 1'b0, CLR = 1'b0, ACK = 1'b0, NEW_GAME = 1'b0;
  logic [2:0] ANS_A = '0, ANS_B = '0, SEL = '0;
  logic       slot1, ok1, slot2, ok2;
  logic [1:0] judg1, wrong1, hp1, judg2, wrong2, hp2;
  int         errs = 0, checks = 0;

  always #5 CLK = ~CLK;

  answer_judge #(.HP_INIT(3), .WRONG_MAX(3), .SW(3)) u_dut (
    .CLK(CLK), .RST(RST), .QUE_START(QUE_START), .ANS_A(ANS_A), .ANS_B(ANS_B),
    .SEL(SEL), .DEC(DEC), .CLR(CLR), .ACK(ACK), .NEW_GAME(NEW_GAME),
    .SLOT_OUT(slot1), .OK_OUT(ok1), .JUDG_OUT(judg1), .WRONG_OUT(wrong1), .HP_OUT(hp1));

  answer_judge #(.HP_INIT(3), .WRONG_MAX(2), .SW(3)) u_dut2 (
    .CLK(CLK), .RST(RST), .QUE_START(QUE_START), .ANS_A(ANS_A), .ANS_B(ANS_B),
    .SEL(SEL), .DEC(DEC), .CLR(CLR), .ACK(ACK), .NEW_GAME(NEW_GAME),
    .SLOT_OUT(slot2), .OK_OUT(ok2), .JUDG_OUT(judg2), .WRONG_OUT(wrong2), .HP_OUT(hp2));

  task chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // packs {SLOT,OK,JUDG,WRONG,HP} of each instance
  function automatic logic [7:0] st1();
    return {slot1, ok1, judg1, wrong1, hp1};
  endfunction
  function automatic logic [7:0] st2();
    return {slot2, ok2, judg2, wrong2, hp2};
  endfunction
  function automatic logic [7:0] exp(input logic s, input logic o, input logic [1:0] j,
                                     input logic [1:0] w, input logic [1:0] h);
    return {s, o, j, w, h};
  endfunction

  task step();
    @(posedge CLK);
    #1;
  endtask
  task reset();
    RST = 1'b1; step(); RST = 1'b0;
  endtask
  task qstart(input logic [2:0] a, input logic [2:0] b);
    ANS_A = a; ANS_B = b; QUE_START = 1'b1; step(); QUE_START = 1'b0;
  endtask
  task dec(input logic [2:0] s);
    SEL = s; DEC = 1'b1; step(); DEC = 1'b0;
  endtask
  task ack();
    ACK = 1'b1; step(); ACK = 1'b0;
  endtask

  initial begin
    step();
    reset();
    chk("reset", st1(), exp(0, 0, 2'b00, 0, 3));

    // correct pair entered in swapped order
    qstart(2, 5);
    dec(5);
    chk("slot1", st1(), exp(1, 0, 2'b00, 0, 3));
    dec(2);
    chk("judge_cycle", st1(), exp(0, 0, 2'b00, 0, 3));
    step();
    chk("correct", st1(), exp(0, 1, 2'b01, 0, 3));
    step();
    chk("correct_hold", st1(), exp(0, 1, 2'b01, 0, 3));
    ack();
    chk("ack_correct", st1(), exp(0, 0, 2'b00, 0, 3));
    dec(4);
    chk("idle_ignores_dec", st1(), exp(0, 0, 2'b00, 0, 3));

    // wrong then retry correct
    qstart(2, 5);
    dec(2); dec(3); step();
    chk("wrong1", st1(), exp(0, 1, 2'b10, 1, 2));
    ack();
    chk("retry_slot0", st1(), exp(0, 0, 2'b00, 1, 2));
    dec(2); dec(5); step();
    chk("retry_ok", st1(), exp(0, 1, 2'b01, 1, 2));
    ack();

    // three wrongs -> game over
    reset();
    qstart(1, 6);
    dec(1); dec(1); step();
    chk("go_w1", st1(), exp(0, 1, 2'b10, 1, 2));
    ack();
    dec(0); dec(0); step();
    chk("go_w2", st1(), exp(0, 1, 2'b10, 2, 1));
    ack();
    dec(6); dec(6); step();
    chk("go_over", st1(), exp(0, 1, 2'b11, 3, 0));
    ack();
    chk("over_ack_ignored", st1(), exp(0, 1, 2'b11, 3, 0));
    NEW_GAME = 1'b1; step(); NEW_GAME = 1'b0;
    chk("new_game", st1(), exp(0, 0, 2'b00, 0, 3));
    qstart(3, 3);
    chk("idle_after_ng", st1(), exp(0, 0, 2'b00, 0, 3));
    ack(); // nothing pending; state SLOT0

    // CLR beats DEC in SLOT1
    reset();
    qstart(2, 5);
    dec(2);
    SEL = 3'd5; DEC = 1'b1; CLR = 1'b1; step(); DEC = 1'b0; CLR = 1'b0;
    chk("clr_beats_dec", st1(), exp(0, 0, 2'b00, 0, 3));
    step();
    chk("no_judge", st1(), exp(0, 0, 2'b00, 0, 3));
    dec(5);
    chk("relanded_slot0", st1(), exp(1, 0, 2'b00, 0, 3));
    dec(2); step();
    chk("after_clr_ok", st1(), exp(0, 1, 2'b01, 0, 3));
    ack();

    // A==B needs both picks equal
    qstart(4, 4);
    dec(4); dec(1); step();
    chk("aeqb_wrong", st1(), exp(0, 1, 2'b10, 1, 2));
    ack();
    dec(4); dec(4); step();
    chk("aeqb_ok", st1(), exp(0, 1, 2'b01, 1, 2));
    ack();

    // WRONG_MAX=2 instance: forfeit after two wrongs, QUE_START ignored in RESULT
    reset();
    qstart(3, 7);
    dec(3); dec(3); step();
    chk("wm2_w1", st2(), exp(0, 1, 2'b10, 1, 2));
    ANS_A = 3'd1; ANS_B = 3'd1; QUE_START = 1'b1; step(); QUE_START = 1'b0;
    chk("wm2_qs_ignored", st2(), exp(0, 1, 2'b10, 1, 2));
    ack();
    dec(7); dec(7); step();
    chk("wm2_w2", st2(), exp(0, 1, 2'b10, 2, 1));
    ack();
    chk("wm2_forfeit", st2(), exp(0, 0, 2'b00, 2, 1));
    dec(3);
    chk("wm2_idle", st2(), exp(0, 0, 2'b00, 2, 1));

    // reset mid-question and from RESULT
    reset();
    qstart(2, 5);
    dec(2);
    chk("pre_rst_slot1", st1(), exp(1, 0, 2'b00, 0, 3));
    reset();
    chk("rst_slot1", st1(), exp(0, 0, 2'b00, 0, 3));
    dec(2);
    chk("rst_idle", st1(), exp(0, 0, 2'b00, 0, 3));
    qstart(2, 5);
    dec(1); dec(1); step();
    chk("pre_rst_result", st1(), exp(0, 1, 2'b10, 1, 2));
    reset();
    chk("rst_result", st1(), exp(0, 0, 2'b00, 0, 3));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/answer_judge.md
Name: answer_judge

Overview:
- Upstream neighbour of the quiz CONTROL block.
- Collects the player's two factor selections for the current factorization question and compares them, in either order, against the expected pair.
- Maintains hit points and the per-question wrong count.
- Presents JUDG/WRONG/HP/OK to CONTROL and holds the verdict until CONTROL acknowledges it.

Parameters:
- HP_INIT, 3, hit points loaded at reset/new game (1..3, fits 2 bits)
- WRONG_MAX, 3, wrong answers allowed per question before forfeit (1..3)
- SW, 3, width of one selection code

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- QUE_START  in  1  one-cycle pulse: new question presented
- ANS_A  in  SW  expected factor code A; sampled on QUE_START
- ANS_B  in  SW  expected factor code B; sampled on QUE_START
- SEL  in  SW  current selection code from switches
- DEC  in  1  one-cycle decide pulse; commits SEL into current slot
- CLR  in  1  one-cycle clear pulse; discards entry of current question
- ACK  in  1  one-cycle pulse from CONTROL: verdict consumed
- NEW_GAME  in  1  one-cycle pulse: leave OVER, reload HP
- SLOT_OUT  out  1  slot being entered (0 = first, 1 = second)
- OK_OUT  out  1  verdict valid; held until ACK
- JUDG_OUT  out  2  00 none, 01 correct, 10 wrong, 11 game over
- WRONG_OUT  out  2  wrong count for current question, saturating
- HP_OUT  out  2  remaining hit points

Behaviour:
- Reset (RST=1 at an edge, from any state, mid-question included):
  - state=IDLE, HP_OUT=HP_INIT, WRONG_OUT=0, JUDG_OUT=00, OK_OUT=0, SLOT_OUT=0.
  - Latched answers and picks cleared to 0.
- IDLE:
  - QUE_START=1: latch ANS_A/ANS_B; WRONG_OUT<=0; JUDG_OUT<=00; go SLOT0.
  - DEC, CLR, ACK ignored.
- SLOT0 (SLOT_OUT=0):
  - DEC: pick0<=SEL; go SLOT1.
  - CLR: stay.
- SLOT1 (SLOT_OUT=1):
  - DEC: pick1<=SEL; go JUDGE.
  - CLR: pick0<=0; go SLOT0.
- Priority: CLR beats DEC in the same cycle. QUE_START is ignored outside IDLE.
- JUDGE (exactly one cycle, no inputs sampled):
  - Correct when (pick0==A && pick1==B) || (pick0==B && pick1==A).
  - A==B requires both picks equal to it.
  - Correct: JUDG<=01.
  - Wrong: WRONG<=WRONG+1, saturating at 3. HP<=HP-1, saturating at 0.
    - New HP==0: JUDG<=11, go OVER.
    - Otherwise: JUDG<=10, go RESULT.
  - OK_OUT<=1 in all cases.
- Latency: DEC accepted in SLOT1 at edge n; JUDGE occupies cycle n+1; OK_OUT/JUDG_OUT/HP_OUT/WRONG_OUT are valid after edge n+1 and stable from edge n+2 onward.
- RESULT: outputs frozen until ACK.
  - ACK and JUDG=01: OK<=0, JUDG<=00, go IDLE.
  - ACK and JUDG=10 and WRONG<WRONG_MAX: OK<=0, JUDG<=00, go SLOT0 (retry same question, picks cleared).
  - ACK and JUDG=10 and WRONG>=WRONG_MAX: OK<=0, JUDG<=00, go IDLE (question forfeited; HP kept).
- OVER:
  - JUDG=11 and OK=1 held. ACK is ignored.
  - NEW_GAME: HP<=HP_INIT, WRONG<=0, JUDG<=00, OK<=0, go IDLE.
  - NEW_GAME in any other state is ignored.
- HP_OUT decrements only in JUDGE and never wraps below 0. WRONG_OUT never wraps above 3.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Reset, then QUE_START with A=2, B=5; DEC with SEL=5, then DEC with SEL=2 -> two edges after second DEC: OK=1, JUDG=01, HP=3, WRONG=0; ACK -> OK=0, JUDG=00, SLOT_OUT=0, back in IDLE.
- A=2, B=5; picks 2,3 -> JUDG=10, WRONG=1, HP=2; ACK -> SLOT_OUT=0 retry; picks 2,5 -> JUDG=01, WRONG=1.
- HP_INIT=3; three wrong answers across questions, with ACK after each -> third verdict gives JUDG=11, HP=0, OK held; ACK ignored; NEW_GAME -> HP=3, JUDG=00, IDLE.
- In SLOT1, assert DEC and CLR in the same cycle -> no judge; SLOT_OUT=0, pick0 cleared; next DEC with SEL=5 lands in slot 0.
- WRONG_MAX=2, HP_INIT=3: wrong, ACK, wrong, ACK -> IDLE with WRONG=2, HP=1; a QUE_START pulsed while in RESULT is ignored.
- RST asserted during SLOT1, and again during RESULT -> next edge: all outputs at reset values, HP=HP_INIT, state IDLE.
